// File: rtl/alu_pkg.sv
// Shared definitions for the ALU datapath: widths, ALU opcodes, the issued
// entry layout and the operand-resolution priority used by the issue stage.
package alu_pkg;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;
    localparam int ALU_OP_W   = 4;
    localparam int NUM_REGS   = 2 ** REG_ADDR_W;

    localparam logic [ALU_OP_W-1:0] ALU_AND = 4'd0;
    localparam logic [ALU_OP_W-1:0] ALU_OR  = 4'd1;
    localparam logic [ALU_OP_W-1:0] ALU_ADD = 4'd2;
    localparam logic [ALU_OP_W-1:0] ALU_SUB = 4'd6;
    localparam logic [ALU_OP_W-1:0] ALU_SLT = 4'd7;
    localparam logic [ALU_OP_W-1:0] ALU_NOR = 4'd12;

    // One instruction as held in the issue stage output register.
    typedef struct packed {
        logic [DATA_W-1:0]     in1;
        logic [DATA_W-1:0]     in2;
        logic [ALU_OP_W-1:0]   op;
        logic [REG_ADDR_W-1:0] rd_addr;
        logic                  reg_write;
    } issue_entry_t;

    // Source-operand priority: R0 is hardwired to zero and never forwarded,
    // then the result leaving the stage this cycle, then the write-back port,
    // and finally the architectural register file.
    function automatic logic [DATA_W-1:0] resolve_operand(
        input logic [REG_ADDR_W-1:0] addr,
        input logic                  ex_en,
        input logic [REG_ADDR_W-1:0] ex_addr,
        input logic [DATA_W-1:0]     ex_data,
        input logic                  wb_en,
        input logic [REG_ADDR_W-1:0] wb_addr,
        input logic [DATA_W-1:0]     wb_data,
        input logic [DATA_W-1:0]     rf_data
    );
        if (addr == '0)
            return '0;
        else if (ex_en && (ex_addr == addr))
            return ex_data;
        else if (wb_en && (wb_addr == addr))
            return wb_data;
        else
            return rf_data;
    endfunction

endpackage

// File: rtl/reg_file_32x32.sv
// 32x32 architectural register file: two combinational read ports, one
// write port committed on the rising clock edge, R0 reads as zero.
module reg_file_32x32
    import alu_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] rs_addr,
    input  logic [REG_ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0]     rs_data,
    output logic [DATA_W-1:0]     rt_data,
    input  logic                  wr_en,
    input  logic [REG_ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0]     wr_data
);

    logic [DATA_W-1:0] regs [NUM_REGS];

    // Register storage: cleared on reset, written by the write-back port.
    // NOTE: this array is built from flops, not a RAM macro, so clearing every
    // entry on reset is legal and required; a RAM would need an init sequence.
    // NOTE: all state updates use <= so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
        end else if (wr_en && (wr_addr != '0)) begin
            regs[wr_addr] <= wr_data;
        end
    end

    assign rs_data = (rs_addr == '0) ? '0 : regs[rs_addr];
    assign rt_data = (rt_addr == '0) ? '0 : regs[rt_addr];

endmodule

// File: rtl/alu_operand_stage.sv
// Operand-fetch/issue stage feeding alu_32bit: reads rs/rt, forwards pending
// results, applies the immediate and holds one instruction for the ALU.
module alu_operand_stage
    import alu_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [REG_ADDR_W-1:0] rs_addr,
    input  logic [REG_ADDR_W-1:0] rt_addr,
    input  logic [DATA_W-1:0]     imm,
    input  logic                  use_imm,
    input  logic [ALU_OP_W-1:0]   alu_op_in,
    input  logic [REG_ADDR_W-1:0] rd_addr,
    input  logic                  reg_write_in,
    input  logic [DATA_W-1:0]     alu_result,
    input  logic                  wb_en,
    input  logic [REG_ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0]     wb_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     alu_in1,
    output logic [DATA_W-1:0]     alu_in2,
    output logic [ALU_OP_W-1:0]   alu_operation,
    output logic [REG_ADDR_W-1:0] out_rd_addr,
    output logic                  out_reg_write
);

    logic              accept;
    logic              handoff;
    logic              ex_fwd_en;
    logic [DATA_W-1:0] rf_rs_data;
    logic [DATA_W-1:0] rf_rt_data;
    logic [DATA_W-1:0] rs_value;
    logic [DATA_W-1:0] rt_value;
    logic              held_valid;
    issue_entry_t      held;
    issue_entry_t      next_entry;

    reg_file_32x32 u_reg_file (
        .clk     (clk),
        .rst     (rst),
        .rs_addr (rs_addr),
        .rt_addr (rt_addr),
        .rs_data (rf_rs_data),
        .rt_data (rf_rt_data),
        .wr_en   (wb_en),
        .wr_addr (wb_addr),
        .wr_data (wb_data)
    );

    // The slot frees up whenever the held entry leaves in the same cycle.
    assign in_ready  = !held_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign handoff   = held_valid && out_ready;
    // alu_result belongs to the held entry and is only final when it leaves.
    assign ex_fwd_en = handoff && held.reg_write;

    assign rs_value = resolve_operand(rs_addr, ex_fwd_en, held.rd_addr, alu_result,
                                      wb_en, wb_addr, wb_data, rf_rs_data);
    assign rt_value = resolve_operand(rt_addr, ex_fwd_en, held.rd_addr, alu_result,
                                      wb_en, wb_addr, wb_data, rf_rt_data);

    // Assemble the entry to capture on accept; rt is irrelevant with an immediate.
    always_comb begin
        // NOTE: a full default first keeps this block free of inferred latches.
        next_entry           = '0;
        next_entry.in1       = rs_value;
        next_entry.in2       = use_imm ? imm : rt_value;
        next_entry.op        = alu_op_in;
        next_entry.rd_addr   = rd_addr;
        next_entry.reg_write = reg_write_in;
    end

    // Single-entry output register: load on accept, drain on handoff, else stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            held_valid <= 1'b0;
            held       <= '0;
        end else if (accept) begin
            held_valid <= 1'b1;
            held       <= next_entry;
        end else if (handoff) begin
            held_valid <= 1'b0;
        end
    end

    assign out_valid     = held_valid;
    assign alu_in1       = held.in1;
    assign alu_in2       = held.in2;
    assign alu_operation = held.op;
    assign out_rd_addr   = held.rd_addr;
    assign out_reg_write = held.reg_write;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Scoreboard bench for alu_operand_stage: directed instructions push expected
// operands; a monitor pops and compares on every handoff. A small ALU model
// and write-back pipe stand in for alu_32bit and the write-back stage.
module tb_alu_operand_stage;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [31:0] imm;
    logic        use_imm;
    logic [3:0]  alu_op_in;
    logic [4:0]  rd_addr;
    logic        reg_write_in;
    logic [31:0] alu_result;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] alu_in1;
    logic [31:0] alu_in2;
    logic [3:0]  alu_operation;
    logic [4:0]  out_rd_addr;
    logic        out_reg_write;

    // Manual write-back driven by stimulus, and the modelled write-back pipe.
    logic        man_en;
    logic [4:0]  man_addr;
    logic [31:0] man_data;
    logic        pipe_en;
    logic [4:0]  pipe_addr;
    logic [31:0] pipe_data;

    typedef struct {
        logic [31:0] in1;
        logic [31:0] in2;
        logic [3:0]  op;
        logic [4:0]  rd;
        logic        rw;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    alu_operand_stage dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .rs_addr       (rs_addr),
        .rt_addr       (rt_addr),
        .imm           (imm),
        .use_imm       (use_imm),
        .alu_op_in     (alu_op_in),
        .rd_addr       (rd_addr),
        .reg_write_in  (reg_write_in),
        .alu_result    (alu_result),
        .wb_en         (wb_en),
        .wb_addr       (wb_addr),
        .wb_data       (wb_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .alu_in1       (alu_in1),
        .alu_in2       (alu_in2),
        .alu_operation (alu_operation),
        .out_rd_addr   (out_rd_addr),
        .out_reg_write (out_reg_write)
    );

    // Behavioural stand-in for alu_32bit.
    always_comb begin
        alu_result = '0;
        case (alu_operation)
            ALU_AND: alu_result = alu_in1 & alu_in2;
            ALU_OR:  alu_result = alu_in1 | alu_in2;
            ALU_ADD: alu_result = alu_in1 + alu_in2;
            ALU_SUB: alu_result = alu_in1 - alu_in2;
            ALU_SLT: alu_result = ($signed(alu_in1) < $signed(alu_in2)) ? 32'd1 : 32'd0;
            ALU_NOR: alu_result = ~(alu_in1 | alu_in2);
            default: alu_result = '0;
        endcase
    end

    // Write-back stage model: a handed-off result appears on wb_* the next cycle.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_en   <= 1'b0;
            pipe_addr <= '0;
            pipe_data <= '0;
        end else begin
            pipe_en   <= out_valid && out_ready && out_reg_write;
            pipe_addr <= out_rd_addr;
            pipe_data <= alu_result;
        end
    end

    assign wb_en   = pipe_en | man_en;
    assign wb_addr = pipe_en ? pipe_addr : man_addr;
    assign wb_data = pipe_en ? pipe_data : man_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: every handoff is compared against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_handoff actual_in1=%h expected=none", alu_in1);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_in1", alu_in1, e.in1);
                    check("sb_in2", alu_in2, e.in2);
                    check("sb_op", 32'(alu_operation), 32'(e.op));
                    check("sb_rd", 32'(out_rd_addr), 32'(e.rd));
                    check("sb_rw", 32'(out_reg_write), 32'(e.rw));
                end
            end
        end
    end

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic [31:0] immv,
                         input logic ui, input logic [3:0] op, input logic [4:0] rd, input logic rw);
        rs_addr      = rs;
        rt_addr      = rt;
        imm          = immv;
        use_imm      = ui;
        alu_op_in    = op;
        rd_addr      = rd;
        reg_write_in = rw;
        in_valid     = 1'b1;
    endtask

    task automatic push(input logic [31:0] in1, input logic [31:0] in2, input logic [3:0] op,
                        input logic [4:0] rd, input logic rw);
        exp_t e;
        e.in1 = in1;
        e.in2 = in2;
        e.op  = op;
        e.rd  = rd;
        e.rw  = rw;
        exp_q.push_back(e);
    endtask

    // Hold in_valid until the stage accepts, bounded to 20 cycles.
    task automatic wait_accept(input string name);
        int   n = 0;
        logic acc;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 20);
        check(name, 32'(acc), 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic issue(input string name, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [31:0] immv, input logic ui, input logic [3:0] op,
                         input logic [4:0] rd, input logic rw,
                         input logic [31:0] e1, input logic [31:0] e2);
        drive(rs, rt, immv, ui, op, rd, rw);
        push(e1, e2, op, rd, rw);
        wait_accept(name);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic man_write(input logic [4:0] addr, input logic [31:0] data);
        man_en   = 1'b1;
        man_addr = addr;
        man_data = data;
        @(posedge clk);
        #1;
        man_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        rs_addr = '0;
        rt_addr = '0;
        imm = '0;
        use_imm = 1'b0;
        alu_op_in = '0;
        rd_addr = '0;
        reg_write_in = 1'b0;
        out_ready = 1'b1;
        man_en = 1'b0;
        man_addr = '0;
        man_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_alu_in1", alu_in1, 32'd0);
        rst = 1'b0;
        idle(1);

        // Register reads: AND of two loaded registers.
        man_write(5'd1, 32'hAAAA_AAAA);
        man_write(5'd2, 32'h5555_5555);
        issue("acc_and", 5'd1, 5'd2, 32'd0, 1'b0, ALU_AND, 5'd7, 1'b0, 32'hAAAA_AAAA, 32'h5555_5555);
        idle(2);

        // Back-to-back EX forwarding: r3=r1+r2, r4=r3-r2, then read r4.
        issue("acc_add", 5'd1, 5'd2, 32'd0, 1'b0, ALU_ADD, 5'd3, 1'b1, 32'hAAAA_AAAA, 32'h5555_5555);
        issue("acc_sub", 5'd3, 5'd2, 32'd0, 1'b0, ALU_SUB, 5'd4, 1'b1, 32'hFFFF_FFFF, 32'h5555_5555);
        issue("acc_or_fwd", 5'd4, 5'd0, 32'd0, 1'b0, ALU_OR, 5'd0, 1'b0, 32'hAAAA_AAAA, 32'd0);
        idle(3);

        // Write-through bypass, and no bypass into R0.
        man_en = 1'b1; man_addr = 5'd6; man_data = 32'h0000_0007;
        issue("acc_byp", 5'd6, 5'd0, 32'd0, 1'b0, ALU_ADD, 5'd0, 1'b0, 32'h0000_0007, 32'd0);
        man_en = 1'b1; man_addr = 5'd0; man_data = 32'h0000_1234;
        issue("acc_r0", 5'd0, 5'd1, 32'd0, 1'b0, ALU_OR, 5'd0, 1'b0, 32'd0, 32'hAAAA_AAAA);
        man_en = 1'b0;
        idle(2);
        issue("acc_rf3", 5'd3, 5'd6, 32'd0, 1'b0, ALU_AND, 5'd0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0007);
        issue("acc_rf4", 5'd4, 5'd0, 32'd0, 1'b0, ALU_AND, 5'd0, 1'b0, 32'hAAAA_AAAA, 32'd0);
        idle(3);

        // Stall: held entry stays put while downstream is not ready.
        out_ready = 1'b0;
        issue("acc_stall_a", 5'd1, 5'd2, 32'd0, 1'b0, ALU_OR, 5'd0, 1'b0, 32'hAAAA_AAAA, 32'h5555_5555);
        drive(5'd2, 5'd1, 32'd0, 1'b0, ALU_ADD, 5'd0, 1'b0);
        push(32'h5555_5555, 32'hAAAA_AAAA, ALU_ADD, 5'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_in_ready", 32'(in_ready), 32'd0);
            check("stall_in1", alu_in1, 32'hAAAA_AAAA);
            check("stall_in2", alu_in2, 32'h5555_5555);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("release_valid", 32'(out_valid), 32'd1);
        check("release_in1", alu_in1, 32'h5555_5555);
        in_valid = 1'b0;
        idle(3);

        // Immediate operand; rt hazard ignored when the immediate is used.
        issue("acc_slt_imm", 5'd1, 5'd2, 32'hFFFF_FFFF, 1'b1, ALU_SLT, 5'd0, 1'b0, 32'hAAAA_AAAA, 32'hFFFF_FFFF);
        issue("acc_add_r2", 5'd1, 5'd1, 32'd0, 1'b0, ALU_ADD, 5'd2, 1'b1, 32'hAAAA_AAAA, 32'hAAAA_AAAA);
        issue("acc_imm_haz", 5'd0, 5'd2, 32'h0000_0010, 1'b1, ALU_SLT, 5'd0, 1'b0, 32'd0, 32'h0000_0010);
        issue("acc_wb_r2", 5'd2, 5'd2, 32'd0, 1'b0, ALU_AND, 5'd0, 1'b0, 32'h5555_5554, 32'h5555_5554);
        // rs==rt both hazarded on the same EX result.
        issue("acc_or_r5", 5'd4, 5'd3, 32'd0, 1'b0, ALU_OR, 5'd5, 1'b1, 32'hAAAA_AAAA, 32'hFFFF_FFFF);
        issue("acc_nor_dup", 5'd5, 5'd5, 32'd0, 1'b0, ALU_NOR, 5'd0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        idle(3);

        // Reset while an entry is held under stall: it is discarded, never written.
        out_ready = 1'b0;
        drive(5'd1, 5'd2, 32'd0, 1'b0, ALU_ADD, 5'd5, 1'b1);
        wait_accept("acc_pre_rst");
        idle(2);
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        #2;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_in1", alu_in1, 32'd0);
        check("mid_rst_in2", alu_in2, 32'd0);
        check("mid_rst_op", 32'(alu_operation), 32'd0);
        check("mid_rst_rd", 32'(out_rd_addr), 32'd0);
        check("mid_rst_rw", 32'(out_reg_write), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        issue("acc_post_rst", 5'd5, 5'd1, 32'd0, 1'b0, ALU_AND, 5'd0, 1'b0, 32'd0, 32'd0);
        idle(4);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
